// File: rtl/e_muldiv.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers (E stage).
// Define MADD_EN to enable madd/maddu (md_op 6/7); otherwise those codes are no-ops.
module e_muldiv #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] MULT_CNT = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_CNT  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [0:0]    state;
    logic [CW-1:0] count;
    logic [63:0]   pending;
    logic          pending_valid;

    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic               div_zero;
    logic               div_ovf;
    logic [31:0]        divisor;
    logic signed [31:0] quot_s;
    logic signed [31:0] rem_s;
    logic [31:0]        quot_u;
    logic [31:0]        rem_u;

    logic          launch;
    logic [63:0]   calc_result;
    logic          calc_valid;
    logic [CW-1:0] calc_count;

    assign div_zero = (src_b == '0);
    assign div_ovf  = (src_a == 32'h8000_0000) && (src_b == 32'hFFFF_FFFF);
    // Zero and overflow divisors are replaced by 1 so the dividers never see an undefined case;
    // both outcomes are resolved separately below.
    assign divisor  = (div_zero || div_ovf) ? 32'd1 : src_b;

    assign prod_s = $signed({{32{src_a[31]}}, src_a}) * $signed({{32{src_b[31]}}, src_b});
    assign prod_u = {32'd0, src_a} * {32'd0, src_b};
    assign quot_s = $signed(src_a) / $signed(divisor);
    assign rem_s  = $signed(src_a) % $signed(divisor);
    assign quot_u = src_a / divisor;
    assign rem_u  = src_a % divisor;

    always_comb begin
        launch      = 1'b0;
        calc_result = '0;
        calc_valid  = 1'b1;
        calc_count  = MULT_CNT;
        case (md_op)
            3'd0: begin
                launch      = 1'b1;
                calc_result = prod_s;
            end
            3'd1: begin
                launch      = 1'b1;
                calc_result = prod_u;
            end
            3'd2: begin
                launch      = 1'b1;
                calc_count  = DIV_CNT;
                calc_valid  = !div_zero;
                calc_result = div_ovf ? {32'd0, 32'h8000_0000} : {rem_s, quot_s};
            end
            3'd3: begin
                launch      = 1'b1;
                calc_count  = DIV_CNT;
                calc_valid  = !div_zero;
                calc_result = {rem_u, quot_u};
            end
`ifdef MADD_EN
            3'd6: begin
                launch      = 1'b1;
                calc_result = {hi, lo} + prod_s;
            end
            3'd7: begin
                launch      = 1'b1;
                calc_result = {hi, lo} + prod_u;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            count         <= '0;
            pending       <= '0;
            pending_valid <= 1'b0;
            hi            <= '0;
            lo            <= '0;
        end else if (state == S_IDLE) begin
            if (start) begin
                if (md_op == 3'd4) hi <= src_a;
                if (md_op == 3'd5) lo <= src_a;
                if (launch) begin
                    pending       <= calc_result;
                    pending_valid <= calc_valid;
                    count         <= calc_count;
                    state         <= S_RUN;
                end
            end
        end else begin
            if (count == CNT_ONE) begin
                if (pending_valid) {hi, lo} <= pending;
                count <= '0;
                state <= S_IDLE;
            end else begin
                count <= count - CNT_ONE;
            end
        end
    end

    assign busy = (state == S_RUN);

endmodule

// File: tb/tb_e_muldiv.sv
// Self-checking bench for e_muldiv against a plain-arithmetic HI/LO model.
module tb_e_muldiv;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  md_op = '0;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    always #5 clk = ~clk;

    e_muldiv #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .md_op(md_op),
        .src_a(src_a), .src_b(src_b), .busy(busy), .hi(hi), .lo(lo)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Architectural effect of one md instruction, plus the busy length it should produce.
    task automatic model_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               output int cyc);
        longint          sa, sb, q, r;
        longint unsigned ua, ub;
        logic [63:0]     acc;
        sa = $signed(a);
        sb = $signed(b);
        ua = 64'(a);
        ub = 64'(b);
        cyc = 0;
        case (op)
            3'd0: begin acc = 64'(sa * sb); {m_hi, m_lo} = acc; cyc = 5; end
            3'd1: begin acc = ua * ub; {m_hi, m_lo} = acc; cyc = 5; end
            3'd2: begin
                cyc = 10;
                if (b != 0) begin q = sa / sb; r = sa % sb; m_lo = 32'(q); m_hi = 32'(r); end
            end
            3'd3: begin
                cyc = 10;
                if (b != 0) begin m_lo = 32'(ua / ub); m_hi = 32'(ua % ub); end
            end
            3'd4: m_hi = a;
            3'd5: m_lo = a;
            default: begin
`ifdef MADD_EN
                acc = {m_hi, m_lo} + ((op == 3'd6) ? 64'(sa * sb) : ua * ub);
                {m_hi, m_lo} = acc;
                cyc = 5;
`endif
            end
        endcase
    endtask

    // Issues one op and measures busy length; returns #1 after the edge where busy is low again.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int cycles, output bit held);
        logic [31:0] h0, l0;
        @(negedge clk);
        start = 1'b1; md_op = op; src_a = a; src_b = b;
        @(posedge clk);
        h0 = hi; l0 = lo;
        #1 start = 1'b0;
        cycles = 0;
        held = 1'b1;
        while (busy === 1'b1 && cycles < 200) begin
            if (hi !== h0 || lo !== l0) held = 1'b0;
            cycles++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (hi !== 32'd0) begin bad++; $display("FAIL reset_hi: got %h want 0", hi); end
        total++; if (lo !== 32'd0) begin bad++; $display("FAIL reset_lo: got %h want 0", lo); end
        reset = 1'b0;
        m_hi = '0; m_lo = '0;
    endtask

    task automatic test_mult();
        int cyc, ecyc; bit held;
        run_op(3'd0, 32'hFFFF_FFFD, 32'd5, cyc, held);
        model_apply(3'd0, 32'hFFFF_FFFD, 32'd5, ecyc);
        total++; if (cyc !== 5) begin bad++; $display("FAIL mult_busy: got %0d want 5", cyc); end
        total++; if (!held) begin bad++; $display("FAIL mult_hold: hi/lo changed during busy want held"); end
        total++; if (hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
        total++; if (lo !== 32'hFFFF_FFF1) begin bad++; $display("FAIL mult_lo: got %h want fffffff1", lo); end
    endtask

    task automatic test_div();
        int cyc, ecyc; bit held;
        run_op(3'd3, 32'd7, 32'd2, cyc, held);
        model_apply(3'd3, 32'd7, 32'd2, ecyc);
        total++; if (cyc !== 10) begin bad++; $display("FAIL divu_busy: got %0d want 10", cyc); end
        total++; if (!held) begin bad++; $display("FAIL divu_hold: hi/lo changed during busy want held"); end
        total++; if (lo !== 32'd3) begin bad++; $display("FAIL divu_lo: got %h want 3", lo); end
        total++; if (hi !== 32'd1) begin bad++; $display("FAIL divu_hi: got %h want 1", hi); end
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, cyc, held);
        model_apply(3'd2, 32'hFFFF_FFF9, 32'd2, ecyc);
        total++; if (cyc !== 10) begin bad++; $display("FAIL div_busy: got %0d want 10", cyc); end
        total++; if (lo !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_lo: got %h want fffffffd", lo); end
        total++; if (hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_hi: got %h want ffffffff", hi); end
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, cyc, held);
        model_apply(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, ecyc);
        total++; if (lo !== 32'h8000_0000) begin bad++; $display("FAIL div_ovf_lo: got %h want 80000000", lo); end
        total++; if (hi !== 32'd0) begin bad++; $display("FAIL div_ovf_hi: got %h want 0", hi); end
    endtask

    task automatic test_mthi_mtlo();
        int cyc, ecyc; bit held;
        run_op(3'd4, 32'h1234_5678, 32'd0, cyc, held);
        model_apply(3'd4, 32'h1234_5678, 32'd0, ecyc);
        total++; if (hi !== 32'h1234_5678) begin bad++; $display("FAIL mthi_hi: got %h want 12345678", hi); end
        total++; if (cyc !== 0) begin bad++; $display("FAIL mthi_busy: got %0d want 0", cyc); end
        run_op(3'd5, 32'h9ABC_DEF0, 32'd0, cyc, held);
        model_apply(3'd5, 32'h9ABC_DEF0, 32'd0, ecyc);
        total++; if (lo !== 32'h9ABC_DEF0) begin bad++; $display("FAIL mtlo_lo: got %h want 9abcdef0", lo); end
        total++; if (cyc !== 0) begin bad++; $display("FAIL mtlo_busy: got %0d want 0", cyc); end
        run_op(3'd2, 32'd100, 32'd0, cyc, held);
        model_apply(3'd2, 32'd100, 32'd0, ecyc);
        total++; if (cyc !== 10) begin bad++; $display("FAIL divzero_busy: got %0d want 10", cyc); end
        total++; if (hi !== 32'h1234_5678) begin bad++; $display("FAIL divzero_hi: got %h want 12345678", hi); end
        total++; if (lo !== 32'h9ABC_DEF0) begin bad++; $display("FAIL divzero_lo: got %h want 9abcdef0", lo); end
    endtask

    task automatic test_ignore_while_busy();
        int cyc, ecyc;
        @(negedge clk);
        start = 1'b1; md_op = 3'd1; src_a = 32'hFFFF_FFFF; src_b = 32'hFFFF_FFFF;
        @(posedge clk); #1 start = 1'b0;
        cyc = 0;
        while (busy === 1'b1 && cyc < 200) begin
            cyc++;
            if (cyc == 2) begin start = 1'b1; md_op = 3'd4; src_a = 32'd1; end
            else start = 1'b0;
            @(posedge clk); #1;
        end
        start = 1'b0;
        model_apply(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, ecyc);
        total++; if (cyc !== 5) begin bad++; $display("FAIL ignore_busy: got %0d want 5", cyc); end
        total++; if (hi !== 32'hFFFF_FFFE) begin bad++; $display("FAIL ignore_hi: got %h want fffffffe", hi); end
        total++; if (lo !== 32'h0000_0001) begin bad++; $display("FAIL ignore_lo: got %h want 00000001", lo); end
    endtask

    task automatic test_reset_abort();
        int cyc, ecyc; bit held;
        @(negedge clk);
        start = 1'b1; md_op = 3'd0; src_a = 32'd2; src_b = 32'd3;
        @(posedge clk); #1 start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort_prebusy: got %b want 1", busy); end
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        m_hi = '0; m_lo = '0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", busy); end
        total++; if (hi !== 32'd0) begin bad++; $display("FAIL abort_hi: got %h want 0", hi); end
        total++; if (lo !== 32'd0) begin bad++; $display("FAIL abort_lo: got %h want 0", lo); end
        run_op(3'd0, 32'd4, 32'd4, cyc, held);
        model_apply(3'd0, 32'd4, 32'd4, ecyc);
        total++; if (cyc !== 5) begin bad++; $display("FAIL post_abort_busy: got %0d want 5", cyc); end
        total++; if (lo !== 32'd16) begin bad++; $display("FAIL post_abort_lo: got %h want 10", lo); end
        total++; if (hi !== 32'd0) begin bad++; $display("FAIL post_abort_hi: got %h want 0", hi); end
    endtask

    task automatic test_madd();
        int cyc, ecyc; bit held;
        run_op(3'd4, 32'd0, 32'd0, cyc, held);
        model_apply(3'd4, 32'd0, 32'd0, ecyc);
        run_op(3'd5, 32'hFFFF_FFFF, 32'd0, cyc, held);
        model_apply(3'd5, 32'hFFFF_FFFF, 32'd0, ecyc);
        run_op(3'd7, 32'd1, 32'd1, cyc, held);
        model_apply(3'd7, 32'd1, 32'd1, ecyc);
`ifdef MADD_EN
        total++; if (cyc !== 5) begin bad++; $display("FAIL maddu_busy: got %0d want 5", cyc); end
        total++; if (hi !== 32'd1) begin bad++; $display("FAIL maddu_hi: got %h want 1", hi); end
        total++; if (lo !== 32'd0) begin bad++; $display("FAIL maddu_lo: got %h want 0", lo); end
`else
        total++; if (cyc !== 0) begin bad++; $display("FAIL maddu_busy: got %0d want 0", cyc); end
        total++; if (hi !== 32'd0) begin bad++; $display("FAIL maddu_hi: got %h want 0", hi); end
        total++; if (lo !== 32'hFFFF_FFFF) begin bad++; $display("FAIL maddu_lo: got %h want ffffffff", lo); end
`endif
    endtask

    task automatic test_random();
        int cyc, ecyc; bit held;
        logic [2:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 9));
                2:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            run_op(op, a, b, cyc, held);
            model_apply(op, a, b, ecyc);
            total++; if (cyc !== ecyc) begin bad++; $display("FAIL rand_busy op=%0d: got %0d want %0d", op, cyc, ecyc); end
            total++; if (!held) begin bad++; $display("FAIL rand_hold op=%0d: hi/lo changed during busy want held", op); end
            total++; if (hi !== m_hi) begin bad++; $display("FAIL rand_hi op=%0d a=%h b=%h: got %h want %h", op, a, b, hi, m_hi); end
            total++; if (lo !== m_lo) begin bad++; $display("FAIL rand_lo op=%0d a=%h b=%h: got %h want %h", op, a, b, lo, m_lo); end
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_mthi_mtlo();
        test_ignore_while_busy();
        test_reset_abort();
        test_madd();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
